// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake states, arbiter FSM states and grant source tags.
package cpu_types_pkg;

  localparam int WORD_BITS = 32;

  typedef logic [WORD_BITS-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } arb_src_t;

  // Index width that stays legal (>=1 bit) even for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set request at or after ptr, wrapping from N-1 back to 0.
module rr_picker
  import cpu_types_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             vld,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    vld  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N);
      if (req[cand[IDX_W-1:0]]) begin
        vld = 1'b1;
        idx = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Multi-core RAM arbiter: data requests beat instruction requests, round-robin within a class,
// one-cycle arbitration in IDLE, grant held in GRANT until ACCESS or until the request drops.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic [CPUS-1:0]              iREN,
  input  logic [CPUS-1:0]              dREN,
  input  logic [CPUS-1:0]              dWEN,
  input  logic [CPUS-1:0][WORD_W-1:0]  iaddr,
  input  logic [CPUS-1:0][WORD_W-1:0]  daddr,
  input  logic [CPUS-1:0][WORD_W-1:0]  dstore,
  output logic [CPUS-1:0]              iwait,
  output logic [CPUS-1:0]              dwait,
  output logic [CPUS-1:0][WORD_W-1:0]  iload,
  output logic [CPUS-1:0][WORD_W-1:0]  dload,
  output logic                         ramREN,
  output logic                         ramWEN,
  output logic [WORD_W-1:0]            ramaddr,
  output logic [WORD_W-1:0]            ramstore,
  input  logic [WORD_W-1:0]            ramload,
  input  ramstate_t                    ramstate
);

  localparam int IDX_W = idx_width(CPUS);

  arb_state_t       state;
  arb_src_t         gnt_src;
  logic [IDX_W-1:0] gnt_core;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] rr_next;

  logic [CPUS-1:0]  d_req;
  logic             d_vld;
  logic             i_vld;
  logic [IDX_W-1:0] d_idx;
  logic [IDX_W-1:0] i_idx;

  logic             gnt_act;
  logic             gnt_rd;
  logic             gnt_wr;
  logic             complete;

  assign d_req = dREN | dWEN;

  rr_picker #(.N(CPUS), .IDX_W(IDX_W)) u_pick_d (
    .req (d_req),
    .ptr (rr_ptr),
    .vld (d_vld),
    .idx (d_idx)
  );

  rr_picker #(.N(CPUS), .IDX_W(IDX_W)) u_pick_i (
    .req (iREN),
    .ptr (rr_ptr),
    .vld (i_vld),
    .idx (i_idx)
  );

  // A data source asserting both enables is serviced as a read.
  always_comb begin
    gnt_act = 1'b0;
    gnt_rd  = 1'b0;
    gnt_wr  = 1'b0;
    if (gnt_src == SRC_D) begin
      gnt_rd  = dREN[gnt_core];
      gnt_wr  = dWEN[gnt_core] & ~dREN[gnt_core];
      gnt_act = dREN[gnt_core] | dWEN[gnt_core];
    end else begin
      gnt_rd  = iREN[gnt_core];
      gnt_act = iREN[gnt_core];
    end
  end

  assign complete = (state == GRANT) && gnt_act && (ramstate == ACCESS);
  assign rr_next  = (gnt_core == IDX_W'(CPUS - 1)) ? '0 : gnt_core + IDX_W'(1);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      gnt_src  <= SRC_I;
      gnt_core <= '0;
      rr_ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_vld) begin
            gnt_src  <= SRC_D;
            gnt_core <= d_idx;
            state    <= GRANT;
          end else if (i_vld) begin
            gnt_src  <= SRC_I;
            gnt_core <= i_idx;
            state    <= GRANT;
          end
        end
        GRANT: begin
          // A dropped request aborts without moving the round-robin pointer.
          if (!gnt_act) begin
            state <= IDLE;
          end else if (ramstate == ACCESS) begin
            state  <= IDLE;
            rr_ptr <= rr_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    iwait    = iREN;
    dwait    = d_req;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (state == GRANT && gnt_act) begin
      ramREN  = gnt_rd;
      ramWEN  = gnt_wr;
      ramaddr = (gnt_src == SRC_D) ? daddr[gnt_core] : iaddr[gnt_core];
      if (gnt_wr) ramstore = dstore[gnt_core];
      if (complete) begin
        if (gnt_src == SRC_D) begin
          dwait[gnt_core] = 1'b0;
          dload[gnt_core] = ramload;
        end else begin
          iwait[gnt_core] = 1'b0;
          iload[gnt_core] = ramload;
        end
      end
    end
  end

endmodule
